seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display that shares one combinational BCD/hex-to-segment decoder across all digits.
- Holds a 16-bit display value (4 hex nibbles) and rotates digit enables at a divided refresh rate.
- Presents one nibble per slot to the shared decoder.
- New values use a load handshake and are applied only at frame boundaries, so a frame never shows mixed old/new digits.
- Optionally blanks leading zeros.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot (refresh tick period); legal range 2..65535.
- DIV_W, 16, prescaler counter width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  1 = scanning, 0 = display dark
- blank_lz  input  1  1 = blank leading zero digits
- value_in  input  16  new display value; nibble i drives digit i, digit 0 least significant
- load  input  1  single-cycle request to capture value_in
- pending  output  1  captured value waiting for frame boundary
- update_done  output  1  one-cycle pulse when the captured value becomes visible
- bcd  output  4  nibble to the shared decoder
- an  output  4  digit enables, active-low one-hot; 4'b1111 = all off
- digit_idx  output  2  currently driven digit

Behaviour:
- Reset (async, rst=1): display_reg=0, shadow_reg=0, pending=0, update_done=0, prescaler=0, digit_idx=0, bcd=0, an=4'b1111. All outputs are registered.
- Prescaler:
  - Counts 0..CLK_DIV-1 while enable=1.
  - tick is asserted in the cycle where prescaler==CLK_DIV-1; prescaler then wraps to 0.
- States:
  - OFF (enable=0): an=4'b1111, prescaler=0, digit_idx=0, bcd=0.
  - SCAN (enable=1): digit_idx advances 0→1→2→3→0 on each tick.
- OFF→SCAN on enable rise:
  - The edge that samples enable=1 drives digit 0: an=4'b1110, bcd=display_reg[3:0].
  - The first tick follows CLK_DIV cycles later.
- SCAN→OFF on enable fall: the next edge drives an=4'b1111, digit_idx=0, prescaler=0. display_reg, shadow_reg and pending are retained.
- Slot outputs: on the edge where digit_idx takes value i, the same edge sets:
  - an = ~(1<<i)
  - bcd = nibble i of the display value effective after that edge.
- Load handshake:
  - load=1 captures value_in into shadow_reg and sets pending=1.
  - A load while pending=1 overwrites shadow_reg; the last value wins and no error is raised.
- Frame boundary (tick while digit_idx==3), if pending=1:
  - display_reg<=shadow_reg, pending<=0, update_done<=1 for exactly one cycle.
  - Digit 0 of the new frame already shows the new value.
- Load and boundary in the same cycle:
  - display_reg takes the old shadow_reg.
  - shadow_reg takes value_in.
  - pending stays 1 and update_done pulses.
- pending=1 while in OFF: applied on the next edge (no tearing possible), with the same update_done pulse.
- Leading-zero blanking: digit i (i=1..3) is blanked when blank_lz=1 and nibbles i..3 of display_reg are all 0.
  - A blanked slot drives an=4'b1111 for the whole slot; bcd still carries the nibble.
  - Digit 0 is never blanked.
- blank_lz and enable changes take effect at the next edge; timing is not restarted except on enable fall.
- No combinational path from any input to any output.

Test Plan:
- Reset check: CLK_DIV=4; assert rst mid-scan → immediately an=1111, bcd=0, pending=0, digit_idx=0 without waiting for a clock edge; after release and enable=1 → an=1110.
- Scan order: CLK_DIV=4, load 16'h1A3F, enable=1 → an sequence 1110,1101,1011,0111 every 4 clocks with bcd F,3,A,1; sequence repeats.
- Frame-boundary update:
  - Load 16'h1234 while digit_idx=1 → pending=1; digits 2,3 still show the old value.
  - On the 3→0 tick, update_done pulses once, pending=0, and digit 0 shows bcd=4.
- Last-wins and simultaneous events:
  - Load 16'h1111 then 16'h2222 within one frame → only 2222 appears.
  - A load coinciding with the boundary tick → display takes the prior shadow value and pending stays 1.
- Leading-zero blanking: value 16'h0050, blank_lz=1 → digits 3,2 an=1111, digit 1 shows 5, digit 0 shows 0. Value 16'h0000 → only digit 0 is lit.
- Enable toggle: drop enable mid-frame at digit_idx=2 → next edge an=1111, digit_idx=0. A pending load is applied while off, with one update_done pulse. Re-enable → scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Values are staged in a shadow register and swapped in only at frame boundaries or while dark.
module seg_scan_controller #(
  parameter int CLK_DIV = 50000,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        pending,
  output logic        update_done,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx
);

  typedef enum logic {OFF, SCAN} state_t;

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  state_t            state;
  logic [DIV_W-1:0]  prescaler;
  logic [15:0]       display_reg;
  logic [15:0]       shadow_reg;

  logic              tick;
  logic              apply;
  logic [1:0]        next_idx;
  logic [15:0]       next_disp;
  logic [3:0]        next_nib;
  logic              next_blank;

  always_comb begin
    tick      = (state == SCAN) && enable && (prescaler == LAST);
    // While dark there is no frame to tear, so a pending value goes in at once.
    apply     = pending && ((state == OFF) || (tick && digit_idx == 2'd3));
    next_disp = apply ? shadow_reg : display_reg;
    next_idx  = 2'd0;
    if (state == SCAN) next_idx = digit_idx + {1'b0, tick};
    next_nib  = next_disp[{next_idx, 2'b00} +: 4];
    next_blank = 1'b0;
    case (next_idx)
      2'd1:    next_blank = blank_lz && (next_disp[15:4] == 12'h000);
      2'd2:    next_blank = blank_lz && (next_disp[15:8] == 8'h00);
      2'd3:    next_blank = blank_lz && (next_disp[15:12] == 4'h0);
      default: next_blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= OFF;
      prescaler   <= '0;
      display_reg <= '0;
      shadow_reg  <= '0;
      pending     <= 1'b0;
      update_done <= 1'b0;
      digit_idx   <= 2'd0;
      bcd         <= 4'h0;
      an          <= 4'b1111;
    end else begin
      update_done <= apply;
      if (apply) display_reg <= shadow_reg;
      // A load on the swap edge refills the shadow, so pending stays set.
      if (load) begin
        shadow_reg <= value_in;
        pending    <= 1'b1;
      end else if (apply) begin
        pending    <= 1'b0;
      end

      if (enable) begin
        state     <= SCAN;
        prescaler <= (state == SCAN && !tick) ? prescaler + 1'b1 : '0;
        digit_idx <= next_idx;
        bcd       <= next_nib;
        an        <= next_blank ? 4'b1111 : ~(4'b0001 << next_idx);
      end else begin
        state     <= OFF;
        prescaler <= '0;
        digit_idx <= 2'd0;
        bcd       <= 4'h0;
        an        <= 4'b1111;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: a time-since-enable model predicts every cycle,
// a monitor compares registered outputs just after each clock edge.
module tb_seg_scan_controller;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        blank_lz;
  logic [15:0] value_in;
  logic        load;
  logic        pending;
  logic        update_done;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  seg_scan_controller #(.CLK_DIV(D), .DIV_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .blank_lz(blank_lz),
    .value_in(value_in), .load(load), .pending(pending),
    .update_done(update_done), .bcd(bcd), .an(an), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // Model: m_t counts edges since the edge that turned the display on.
  int          m_t;
  bit          m_on;
  bit          m_pend;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;

  task automatic model_reset();
    m_t = 0; m_on = 0; m_pend = 0; m_disp = '0; m_shadow = '0;
  endtask

  task automatic predict();
    bit was_on, apply, blank;
    int idx;
    logic [3:0] e_an, e_bcd;
    was_on = m_on;
    if (enable) begin
      m_t  = was_on ? m_t + 1 : 0;
      m_on = 1;
    end else begin
      m_on = 0;
    end
    apply = m_pend && (!was_on || (enable && m_t % (4 * D) == 0));
    if (apply) m_disp = m_shadow;
    if (load) begin
      m_shadow = value_in;
      m_pend   = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    if (enable) begin
      idx   = (m_t / D) % 4;
      e_bcd = 4'((m_disp >> (4 * idx)) & 16'hF);
      blank = blank_lz && idx != 0 && (m_disp >> (4 * idx)) == 16'h0;
      e_an  = blank ? 4'b1111 : ~(4'b0001 << idx);
    end else begin
      idx = 0; e_bcd = 4'h0; e_an = 4'b1111;
    end
    exp_q.push_back({m_pend, apply, 2'(idx), e_an, e_bcd});
  endtask

  task automatic step(input logic en, input logic blz, input logic ld, input logic [15:0] val);
    @(negedge clk);
    enable = en; blank_lz = blz; load = ld; value_in = val;
    predict();
  endtask

  task automatic run(input int n, input logic en, input logic blz);
    for (int i = 0; i < n; i++) step(en, blz, 1'b0, 16'h0);
  endtask

  task automatic check_const(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Reset is asserted between edges and checked before any clock edge arrives.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    enable = 0; load = 0; blank_lz = 0; value_in = '0;
    #1;
    check_const("rst_an", an, 4'b1111);
    check_const("rst_bcd", bcd, 4'h0);
    check_const("rst_pending", {3'b0, pending}, 4'h0);
    check_const("rst_idx", {2'b0, digit_idx}, 4'h0);
    check_const("rst_update_done", {3'b0, update_done}, 4'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded wait (in edges) until the model says the given digit is being driven.
  task automatic wait_digit(input int d, input logic blz);
    for (int i = 0; i < 8 * D && ((m_t / D) % 4) != d; i++) step(1'b1, blz, 1'b0, 16'h0);
  endtask

  always @(posedge clk) begin
    logic [11:0] exp, act;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {pending, update_done, digit_idx, an, bcd};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL scan_out t=%0t act pend=%b ud=%b idx=%0d an=%b bcd=%h exp pend=%b ud=%b idx=%0d an=%b bcd=%h",
                 $time, act[11], act[10], act[9:8], act[7:4], act[3:0],
                 exp[11], exp[10], exp[9:8], exp[7:4], exp[3:0]);
      end
    end
  end

  initial begin
    logic [15:0] v;
    logic en, blz;
    rst = 1'b1; enable = 0; blank_lz = 0; load = 0; value_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Scan order with 1A3F, loaded while dark.
    step(1'b0, 1'b0, 1'b1, 16'h1A3F);
    run(2, 1'b0, 1'b0);
    run(8 * D + 3, 1'b1, 1'b0);

    // Load during digit 1; the swap happens only at the 3->0 tick.
    wait_digit(1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h1234);
    run(5 * D, 1'b1, 1'b0);

    // Two loads in one frame: last wins.
    wait_digit(0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h1111);
    run(D, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h2222);
    run(5 * D, 1'b1, 1'b0);

    // Load on the boundary edge itself while a value is already pending.
    step(1'b1, 1'b0, 1'b1, 16'hABCD);
    for (int i = 0; i < 8 * D && (m_t + 1) % (4 * D) != 0; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b1, 16'h5678);
    run(9 * D, 1'b1, 1'b0);

    // Leading-zero blanking.
    step(1'b1, 1'b1, 1'b1, 16'h0050);
    run(9 * D, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h0000);
    run(9 * D, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h0700);
    run(9 * D, 1'b1, 1'b0);

    // Drop enable at digit 2, load while dark, then re-enable.
    wait_digit(2, 1'b0);
    run(1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h9876);
    run(3, 1'b0, 1'b0);
    run(6 * D, 1'b1, 1'b0);

    // Asynchronous reset mid-scan, then restart.
    wait_digit(2, 1'b0);
    async_reset();
    run(2 * D, 1'b1, 1'b0);

    // Randomized traffic with long enable runs and sparse nibbles.
    en = 1; blz = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      for (int n = 0; n < 4; n++) v[n*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(en, blz, ($urandom_range(0, 99) < 10), v);
    end
    run(2, 1'b1, 1'b0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
